id_ex_stage_reg: RTL and testbench

Decode-to-execute pipeline register for the 5-stage RISC-V core. It sits directly downstream of the decode-stage control decoder. It captures that decoder's control bundle together with the decoded operands, and applies the hazard unit's stall (hold) and flush (bubble) requests. It also owns the halt-drain sequence: when a decoded halt reaches EX, it freezes the front end, lets older instructions retire, and then raises `halted`.

---
 rtl/riscv_pkg.sv | 31 +++
 rtl/halt_drain_fsm.sv | 56 +++++
 rtl/id_ex_stage_reg.sv | 194 +++++++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the 5-stage RISC-V core: decoder control bundle,
// ALU-op classes and the halt-drain state encoding.
package riscv_pkg;

  localparam logic [2:0] ALU_OP_LDST   = 3'b000;
  localparam logic [2:0] ALU_OP_BRANCH = 3'b001;
  localparam logic [2:0] ALU_OP_RTYPE  = 3'b010;
  localparam logic [2:0] ALU_OP_ITYPE  = 3'b011;
  localparam logic [2:0] ALU_OP_LUI    = 3'b100;

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] alu_op;
    logic       branch;
    logic [1:0] jal_type;
    logic       halt;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } halt_state_t;

endpackage

// File: rtl/halt_drain_fsm.sv
// Halt-drain sequencer: after a halt is captured into EX, freezes the front
// end, bubbles EX for DRAIN_CYCLES edges so older work retires, then halts.
module halt_drain_fsm
  import riscv_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic clk,
  input  logic reset_ni,
  input  logic capture_i,
  output logic freeze_o,
  output logic halted_o,
  output logic bubble_o
);

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  halt_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (capture_i) begin
          state_d = DRAIN;
          cnt_d   = DRAIN_LAST;
        end
      end
      DRAIN: begin
        if (cnt_q == 4'd0) state_d = HALTED;
        else               cnt_d   = cnt_q - 4'd1;
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    freeze_o = (state_q != RUN);
    halted_o = (state_q == HALTED);
    bubble_o = (state_q != RUN);
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with stall/flush handling and halt detection.
// Define HALT_DRAIN_EN to build the halt-drain FSM; otherwise halted is a sticky flop.
module id_ex_stage_reg
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_alu_src,
  input  logic                  id_mem_to_reg,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_branch,
  input  logic                  id_halt,
  input  logic [2:0]            id_alu_op,
  input  logic [1:0]            id_jal_type,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic [DATA_WIDTH-1:0] id_rd1,
  input  logic [DATA_WIDTH-1:0] id_rd2,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic [4:0]            id_rd,
  input  logic [2:0]            id_funct3,
  input  logic [6:0]            id_funct7,
  output logic                  ex_alu_src,
  output logic                  ex_mem_to_reg,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_branch,
  output logic                  ex_halt,
  output logic [2:0]            ex_alu_op,
  output logic [1:0]            ex_jal_type,
  output logic [DATA_WIDTH-1:0] ex_pc,
  output logic [DATA_WIDTH-1:0] ex_rd1,
  output logic [DATA_WIDTH-1:0] ex_rd2,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [4:0]            ex_rs1,
  output logic [4:0]            ex_rs2,
  output logic [4:0]            ex_rd,
  output logic [2:0]            ex_funct3,
  output logic [6:0]            ex_funct7,
  output logic                  ex_valid,
  output logic                  freeze,
  output logic                  halted
);

  ctrl_t                 ctrl_q, ctrl_d, ctrl_in;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [4:0]            rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [6:0]            funct7_q, funct7_d;
  logic                  fsm_bubble;

  always_comb begin
    ctrl_in = '{alu_src:    id_alu_src,
                mem_to_reg: id_mem_to_reg,
                reg_write:  id_reg_write,
                mem_read:   id_mem_read,
                mem_write:  id_mem_write,
                alu_op:     id_alu_op,
                branch:     id_branch,
                jal_type:   id_jal_type,
                halt:       id_halt};
  end

`ifdef HALT_DRAIN_EN
  logic halt_capture;

  // Only a halt that actually loads (not flushed, not stalled) starts the drain.
  assign halt_capture = id_valid & id_halt & ~flush & ~stall;

  halt_drain_fsm #(
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) u_halt_drain_fsm (
    .clk      (clk),
    .reset_ni (reset),
    .capture_i(halt_capture),
    .freeze_o (freeze),
    .halted_o (halted),
    .bubble_o (fsm_bubble)
  );
`else
  logic halted_q, halted_d;

  assign fsm_bubble = 1'b0;
  assign halted_d   = halted_q | (valid_q & ctrl_q.halt);

  always_ff @(posedge clk) begin
    if (!reset) halted_q <= 1'b0;
    else        halted_q <= halted_d;
  end

  assign halted = halted_q;
  assign freeze = halted_q;
`endif

  always_comb begin
    ctrl_d   = ctrl_q;
    valid_d  = valid_q;
    pc_d     = pc_q;
    rd1_d    = rd1_q;
    rd2_d    = rd2_q;
    imm_d    = imm_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    funct3_d = funct3_q;
    funct7_d = funct7_q;
    if (fsm_bubble || flush) begin
      ctrl_d   = CTRL_BUBBLE;
      valid_d  = 1'b0;
      pc_d     = '0;
      rd1_d    = '0;
      rd2_d    = '0;
      imm_d    = '0;
      rs1_d    = '0;
      rs2_d    = '0;
      rd_d     = '0;
      funct3_d = '0;
      funct7_d = '0;
    end else if (!stall) begin
      // Controls of a non-instruction are squashed; data passes through.
      ctrl_d   = id_valid ? ctrl_in : CTRL_BUBBLE;
      valid_d  = id_valid;
      pc_d     = id_pc;
      rd1_d    = id_rd1;
      rd2_d    = id_rd2;
      imm_d    = id_imm;
      rs1_d    = id_rs1;
      rs2_d    = id_rs2;
      rd_d     = id_rd;
      funct3_d = id_funct3;
      funct7_d = id_funct7;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q   <= CTRL_BUBBLE;
      valid_q  <= 1'b0;
      pc_q     <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      imm_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      funct3_q <= '0;
      funct7_q <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      imm_q    <= imm_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      funct3_q <= funct3_d;
      funct7_q <= funct7_d;
    end
  end

  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_branch     = ctrl_q.branch;
  assign ex_halt       = ctrl_q.halt;
  assign ex_alu_op     = ctrl_q.alu_op;
  assign ex_jal_type   = ctrl_q.jal_type;
  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_rd1        = rd1_q;
  assign ex_rd2        = rd2_q;
  assign ex_imm        = imm_q;
  assign ex_rs1        = rs1_q;
  assign ex_rs2        = rs2_q;
  assign ex_rd         = rd_q;
  assign ex_funct3     = funct3_q;
  assign ex_funct7     = funct7_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Table-driven bench for id_ex_stage_reg with a scoreboard queue; expectations
// follow HALT_DRAIN_EN when it is defined, the sticky-halt behaviour otherwise.
module tb_id_ex_stage_reg;

  localparam int DW = 32;
  localparam int DC = 3;
`ifdef HALT_DRAIN_EN
  localparam logic HF = 1'b1;
  localparam int   HALT_LAT = DC;
`else
  localparam logic HF = 1'b0;
  localparam int   HALT_LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset, id_valid, stall, flush;
  logic id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write, id_branch, id_halt;
  logic [2:0] id_alu_op, id_funct3;
  logic [1:0] id_jal_type;
  logic [DW-1:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [6:0] id_funct7;
  logic ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_halt;
  logic [2:0] ex_alu_op, ex_funct3;
  logic [1:0] ex_jal_type;
  logic [DW-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [6:0] ex_funct7;
  logic ex_valid, freeze, halted;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.DATA_WIDTH(DW), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .stall(stall), .flush(flush),
    .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
    .id_halt(id_halt), .id_alu_op(id_alu_op), .id_jal_type(id_jal_type),
    .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_halt(ex_halt), .ex_alu_op(ex_alu_op), .ex_jal_type(ex_jal_type),
    .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_valid(ex_valid), .freeze(freeze), .halted(halted)
  );

  typedef struct {
    logic rst_n, valid, stl, fls, rw, mw, halt;
    logic [2:0] alu;
    logic [DW-1:0] rd1;
    logic e_valid, e_rw, e_mw, e_halt;
    logic [2:0] e_alu;
    logic [DW-1:0] e_rd1;
    logic e_freeze, e_halted;
  } vec_t;

  typedef struct packed {
    logic valid, rw, mw, mem_read, branch, halt;
    logic [1:0] jal;
    logic [2:0] alu, funct3;
    logic [DW-1:0] rd1, pc, imm;
    logic [4:0] rd;
    logic freeze, halted;
  } obs_t;

  int n_tests = 0;
  int n_fail  = 0;
  obs_t sb_q[$];
  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic v, logic s, logic f, logic rw, logic mw, logic h,
                              logic [2:0] a, logic [DW-1:0] d,
                              logic ev, logic erw, logic emw, logic eh, logic [2:0] ea,
                              logic [DW-1:0] ed, logic efz, logic eht);
    vec_t t;
    t.rst_n = r; t.valid = v; t.stl = s; t.fls = f; t.rw = rw; t.mw = mw; t.halt = h;
    t.alu = a; t.rd1 = d; t.e_valid = ev; t.e_rw = erw; t.e_mw = emw; t.e_halt = eh;
    t.e_alu = ea; t.e_rd1 = ed; t.e_freeze = efz; t.e_halted = eht;
    return t;
  endfunction

  // Secondary fields are driven as fixed functions of rd1/rw/mw, so their expectations follow.
  function automatic obs_t expect_of(vec_t t);
    obs_t e;
    logic dz;
    dz = (t.e_rd1 == '0);
    e.valid = t.e_valid; e.rw = t.e_rw; e.mw = t.e_mw; e.mem_read = t.e_mw;
    e.branch = t.e_rw; e.halt = t.e_halt; e.jal = {t.e_mw, t.e_rw}; e.alu = t.e_alu;
    e.funct3 = t.e_rd1[2:0]; e.rd1 = t.e_rd1;
    e.pc = dz ? '0 : (t.e_rd1 ^ 32'h0000_1000);
    e.imm = dz ? '0 : ~t.e_rd1;
    e.rd = t.e_rd1[4:0]; e.freeze = t.e_freeze; e.halted = t.e_halted;
    return e;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.valid = ex_valid; o.rw = ex_reg_write; o.mw = ex_mem_write; o.mem_read = ex_mem_read;
    o.branch = ex_branch; o.halt = ex_halt; o.jal = ex_jal_type; o.alu = ex_alu_op;
    o.funct3 = ex_funct3; o.rd1 = ex_rd1; o.pc = ex_pc; o.imm = ex_imm; o.rd = ex_rd;
    o.freeze = freeze; o.halted = halted;
    return o;
  endfunction

  task automatic drive(vec_t t);
    reset = t.rst_n; id_valid = t.valid; stall = t.stl; flush = t.fls;
    id_reg_write = t.rw; id_mem_write = t.mw; id_mem_read = t.mw; id_branch = t.rw;
    id_jal_type = {t.mw, t.rw}; id_halt = t.halt; id_alu_op = t.alu;
    id_rd1 = t.rd1; id_pc = t.rd1 ^ 32'h0000_1000; id_imm = ~t.rd1; id_rd = t.rd1[4:0];
    id_funct3 = t.rd1[2:0]; id_rd2 = t.rd1 + 32'd1; id_rs1 = 5'd3; id_rs2 = 5'd7;
    id_funct7 = 7'h20; id_alu_src = 1'b1; id_mem_to_reg = 1'b1;
  endtask

  task automatic apply(int idx, vec_t t);
    obs_t got, exp;
    drive(t);
    sb_q.push_back(expect_of(t));
    @(posedge clk);
    #1;
    got = observe();
    exp = sb_q.pop_front();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL vec%0d: got %h required %h", idx, got, exp);
    end else begin
      $display("[TB] vec%0d ok valid=%0b alu=%0h rd1=%h freeze=%0b halted=%0b",
               idx, got.valid, got.alu, got.rd1, got.freeze, got.halted);
    end
  endtask

  initial begin
    int n;
    // reset held with live inputs
    tbl.push_back(mk(0,1,0,0,1,1,1,3'b010,$urandom(), 0,0,0,0,3'b000,'0,0,0));
    tbl.push_back(mk(0,1,0,0,1,1,1,3'b010,$urandom(), 0,0,0,0,3'b000,'0,0,0));
    // load then stall three cycles with new inputs, then release
    tbl.push_back(mk(1,1,0,0,1,0,0,3'b010,32'h1234, 1,1,0,0,3'b010,32'h1234,0,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,1,1,0,0,1,0,3'b011,32'hBEEF, 1,1,0,0,3'b010,32'h1234,0,0));
    tbl.push_back(mk(1,1,0,0,0,1,0,3'b011,32'hBEEF, 1,0,1,0,3'b011,32'hBEEF,0,0));
    // invalid slot: controls squashed, data passes
    tbl.push_back(mk(1,0,0,0,1,0,0,3'b100,32'h55, 0,0,0,0,3'b000,32'h55,0,0));
    // flush beats stall
    tbl.push_back(mk(1,1,0,0,1,1,0,3'b010,32'h77, 1,1,1,0,3'b010,32'h77,0,0));
    tbl.push_back(mk(1,1,1,1,1,1,0,3'b010,32'h88, 0,0,0,0,3'b000,'0,0,0));
    // wrong-path halt is flushed, loads continue
    tbl.push_back(mk(1,1,0,1,0,0,1,3'b000,32'h90, 0,0,0,0,3'b000,'0,0,0));
    tbl.push_back(mk(1,1,0,0,1,0,0,3'b001,32'h99, 1,1,0,0,3'b001,32'h99,0,0));
    // real halt enters EX
    tbl.push_back(mk(1,1,0,0,0,0,1,3'b000,32'hAA, 1,0,0,1,3'b000,32'hAA,HF,0));
`ifdef HALT_DRAIN_EN
    tbl.push_back(mk(1,1,0,0,1,0,0,3'b010,32'hBB, 0,0,0,0,3'b000,'0,1,0));
    tbl.push_back(mk(1,1,1,0,0,0,0,3'b011,32'hCC, 0,0,0,0,3'b000,'0,1,0));
    tbl.push_back(mk(1,1,0,1,1,1,0,3'b010,32'hDD, 0,0,0,0,3'b000,'0,1,1));
    tbl.push_back(mk(1,1,0,0,1,0,0,3'b010,32'hEE, 0,0,0,0,3'b000,'0,1,1));
`else
    tbl.push_back(mk(1,1,0,0,1,0,0,3'b010,32'hBB, 1,1,0,0,3'b010,32'hBB,1,1));
    tbl.push_back(mk(1,1,1,0,0,0,0,3'b011,32'hCC, 1,1,0,0,3'b010,32'hBB,1,1));
    tbl.push_back(mk(1,1,0,1,1,1,0,3'b010,32'hDD, 0,0,0,0,3'b000,'0,1,1));
    tbl.push_back(mk(1,1,0,0,1,0,0,3'b010,32'hEE, 1,1,0,0,3'b010,32'hEE,1,1));
`endif
    // reset clears halted; halt again and reset one cycle into the drain
    tbl.push_back(mk(0,1,0,0,1,1,1,3'b010,$urandom(), 0,0,0,0,3'b000,'0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,1,3'b000,32'h44, 1,0,0,1,3'b000,32'h44,HF,0));
    tbl.push_back(mk(0,1,0,0,1,0,0,3'b010,32'h66, 0,0,0,0,3'b000,'0,0,0));
    tbl.push_back(mk(1,1,0,0,1,0,0,3'b010,32'h66, 1,1,0,0,3'b010,32'h66,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,1,3'b000,32'h321, 1,0,0,1,3'b000,32'h321,HF,0));

    drive(tbl[0]);
    @(negedge clk);
    foreach (tbl[i]) apply(i, tbl[i]);

    // halted latency measured from the edge where ex_halt became visible
    id_valid = 1'b0; id_halt = 1'b0;
    n = 0;
    while (halted !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_tests++;
    if (n != HALT_LAT) begin
      n_fail++;
      $display("FAIL halt_latency: got %0d edges required %0d", n, HALT_LAT);
    end else begin
      $display("[TB] halt_latency ok edges=%0d", n);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
